// File: rtl/psum_col_accum.sv
// psum_col_accum
// Accumulates partial-product columns from the multiplier array across input
// channels. There is one accumulator bank per kernel-column index. A
// last-channel beat sends the finished, saturated column to a single output
// slot and clears its bank. The slot uses a valid/ready handshake.
module psum_col_accum #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int ACC_WIDTH     = 24
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0] i_psum_col,
    input  logic [2:0]                           i_kercol_idx,
    input  logic                                 i_psum_valid,
    input  logic                                 i_first_ch,
    input  logic                                 i_last_ch,
    output logic                                 o_psum_ready,
    output logic [ACC_WIDTH*NO_COL_KERNEL-1:0]   o_acc_col,
    output logic [2:0]                           o_acc_kercol,
    output logic                                 o_acc_valid,
    input  logic                                 i_acc_ready,
    output logic                                 o_sat_err,
    output logic                                 o_idx_err
);

    // Product width, and the sum width: one guard bit above the accumulator,
    // which is enough to see any overflow of accumulator + product.
    localparam int PW = 2 * BIT_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    // Clamp a guarded sum back into the signed accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SW-1:0] v);
        if (v[SW-1] != v[SW-2]) begin
            if (v[SW-1])
                return {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                return {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return v[ACC_WIDTH-1:0];
    endfunction

    // True when the guarded sum does not fit the accumulator range.
    function automatic logic sat_hit(input logic signed [SW-1:0] v);
        return v[SW-1] != v[SW-2];
    endfunction

    logic signed [ACC_WIDTH-1:0]         bank     [NO_COL_KERNEL][NO_COL_KERNEL];
    logic signed [ACC_WIDTH-1:0]         sel_bank [NO_COL_KERNEL];
    logic signed [ACC_WIDTH-1:0]         sum_p0   [NO_COL_KERNEL];
    logic [ACC_WIDTH*NO_COL_KERNEL-1:0]  sum_flat_p0;
    logic signed [PW-1:0]                prod;
    logic signed [ACC_WIDTH-1:0]         base;
    logic signed [SW-1:0]                wide;
    logic                                lane_sat_p0;

    logic                                idx_ok;
    logic                                accept;
    logic                                beat_ok;

    logic [ACC_WIDTH*NO_COL_KERNEL-1:0]  acc_col_p1;
    logic [2:0]                          acc_kercol_p1;
    logic                                vld_p1;
    logic                                sat_err;
    logic                                idx_err;

    // Handshake and index qualification. The input stalls only while a result
    // sits in the slot and downstream is not taking it.
    always_comb begin
        o_psum_ready = !vld_p1 || i_acc_ready;
        idx_ok       = 32'(i_kercol_idx) < NO_COL_KERNEL;
        accept       = i_psum_valid && o_psum_ready;
        beat_ok      = accept && idx_ok;
    end

    // Read the addressed bank. An out-of-range index reads zeros, and that
    // beat is discarded anyway.
    always_comb begin
        sel_bank = '{default: '0};
        for (int b = 0; b < NO_COL_KERNEL; b++) begin
            if (32'(i_kercol_idx) == b)
                sel_bank = bank[b];
        end
    end

    // Per-lane sum. A first-channel beat loads the bank instead of adding to it.
    always_comb begin
        sum_p0      = '{default: '0};
        sum_flat_p0 = '0;
        lane_sat_p0 = 1'b0;
        prod        = '0;
        base        = '0;
        wide        = '0;
        for (int j = 0; j < NO_COL_KERNEL; j++) begin
            prod = i_psum_col[j*PW +: PW];
            base = i_first_ch ? '0 : sel_bank[j];
            wide = {{(SW-PW){prod[PW-1]}}, prod} + {base[ACC_WIDTH-1], base};
            sum_p0[j] = sat_acc(wide);
            sum_flat_p0[j*ACC_WIDTH +: ACC_WIDTH] = sum_p0[j];
            lane_sat_p0 = lane_sat_p0 | sat_hit(wide);
        end
    end

    // ---- stage p0 -> bank state ----
    // Update the addressed bank. A last-channel beat clears it and passes the sum on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < NO_COL_KERNEL; b++)
                for (int j = 0; j < NO_COL_KERNEL; j++)
                    bank[b][j] <= '0;
        end else if (beat_ok) begin
            for (int b = 0; b < NO_COL_KERNEL; b++) begin
                if (32'(i_kercol_idx) == b) begin
                    for (int j = 0; j < NO_COL_KERNEL; j++)
                        bank[b][j] <= i_last_ch ? '0 : sum_p0[j];
                end
            end
        end
    end

    // ---- stage p0 -> p1 output slot ----
    // Load the finished column. A new result can replace a draining one on the
    // same edge, so back-to-back results leave no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1        <= 1'b0;
            acc_col_p1    <= '0;
            acc_kercol_p1 <= '0;
        end else if (beat_ok && i_last_ch) begin
            vld_p1        <= 1'b1;
            acc_col_p1    <= sum_flat_p0;
            acc_kercol_p1 <= i_kercol_idx;
        end else if (i_acc_ready) begin
            vld_p1        <= 1'b0;
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_err <= 1'b0;
            idx_err <= 1'b0;
        end else begin
            sat_err <= sat_err | (beat_ok & lane_sat_p0);
            idx_err <= idx_err | (accept & !idx_ok);
        end
    end

    assign o_acc_col    = acc_col_p1;
    assign o_acc_kercol = acc_kercol_p1;
    assign o_acc_valid  = vld_p1;
    assign o_sat_err    = sat_err;
    assign o_idx_err    = idx_err;

endmodule

// File: tb/tb_psum_col_accum.sv
// tb_psum_col_accum
// Directed and random bench for psum_col_accum. The bench runs two instances
// on the same stimulus: the default 24-bit accumulator and a 17-bit one that
// saturates. A reference model predicts the expected results. It holds integer
// banks, clamps every sum, and keeps a queue of pending results.
module tb_psum_col_accum;

    localparam int BW  = 8;
    localparam int NK  = 5;
    localparam int AW  = 24;
    localparam int AWS = 17;
    localparam int PW  = 2 * BW;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [PW*NK-1:0]   i_psum_col;
    logic [2:0]         i_kercol_idx;
    logic               i_psum_valid;
    logic               i_first_ch;
    logic               i_last_ch;
    logic               i_acc_ready;

    logic               o_psum_ready, o_acc_valid, o_sat_err, o_idx_err;
    logic [AW*NK-1:0]   o_acc_col;
    logic [2:0]         o_acc_kercol;

    logic               s_psum_ready, s_acc_valid, s_sat_err, s_idx_err;
    logic [AWS*NK-1:0]  s_acc_col;
    logic [2:0]         s_acc_kercol;

    psum_col_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .ACC_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_psum_col(i_psum_col), .i_kercol_idx(i_kercol_idx),
        .i_psum_valid(i_psum_valid), .i_first_ch(i_first_ch), .i_last_ch(i_last_ch),
        .o_psum_ready(o_psum_ready), .o_acc_col(o_acc_col), .o_acc_kercol(o_acc_kercol),
        .o_acc_valid(o_acc_valid), .i_acc_ready(i_acc_ready),
        .o_sat_err(o_sat_err), .o_idx_err(o_idx_err)
    );

    psum_col_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .ACC_WIDTH(AWS)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_psum_col(i_psum_col), .i_kercol_idx(i_kercol_idx),
        .i_psum_valid(i_psum_valid), .i_first_ch(i_first_ch), .i_last_ch(i_last_ch),
        .o_psum_ready(s_psum_ready), .o_acc_col(s_acc_col), .o_acc_kercol(s_acc_kercol),
        .o_acc_valid(s_acc_valid), .i_acc_ready(i_acc_ready),
        .o_sat_err(s_sat_err), .o_idx_err(s_idx_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int     k;
        longint v24[NK];
        longint v17[NK];
    } res_t;

    res_t   q[$];
    longint b24[NK][NK];
    longint b17[NK][NK];
    bit     m_sat24, m_sat17, m_idx;
    int     lane[NK];
    int     n_cmp = 0;
    int     n_err = 0;

    function automatic longint clamp(input longint s, input int w, output bit hit);
        longint mx, mn;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -(longint'(1) << (w - 1));
        hit = 1'b0;
        if (s > mx) begin hit = 1'b1; return mx; end
        if (s < mn) begin hit = 1'b1; return mn; end
        return s;
    endfunction

    function automatic logic [127:0] pack(input longint v[NK], input int w);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < NK; j++)
            for (int b = 0; b < w; b++)
                r[j*w + b] = v[j][b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int v);
        for (int j = 0; j < NK; j++) lane[j] = v;
    endtask

    task automatic model_clear();
        for (int b = 0; b < NK; b++)
            for (int j = 0; j < NK; j++) begin
                b24[b][j] = 0;
                b17[b][j] = 0;
            end
        m_sat24 = 1'b0;
        m_sat17 = 1'b0;
        m_idx   = 1'b0;
        q.delete();
    endtask

    // One clock: drive the inputs and check the handshake and slot contents
    // before the edge. Advance the model, then check the sticky flags after the edge.
    task automatic cycle(input bit v, input int k, input bit f, input bit l, input bit rdy);
        bit     exp_rdy, hit;
        res_t   r;
        longint s;
        i_psum_valid = v;
        i_kercol_idx = 3'(k);
        i_first_ch   = f;
        i_last_ch    = l;
        i_acc_ready  = rdy;
        for (int j = 0; j < NK; j++) i_psum_col[j*PW +: PW] = PW'(lane[j]);
        #1;
        exp_rdy = (q.size() == 0) || rdy;
        chk("psum_ready",   128'(o_psum_ready), 128'(exp_rdy));
        chk("psum_ready_s", 128'(s_psum_ready), 128'(exp_rdy));
        chk("acc_valid",    128'(o_acc_valid),  128'(q.size() != 0));
        chk("acc_valid_s",  128'(s_acc_valid),  128'(q.size() != 0));
        if (q.size() != 0) begin
            chk("acc_col",      128'(o_acc_col),    pack(q[0].v24, AW));
            chk("acc_col_s",    128'(s_acc_col),    pack(q[0].v17, AWS));
            chk("acc_kercol",   128'(o_acc_kercol), 128'(q[0].k));
            chk("acc_kercol_s", 128'(s_acc_kercol), 128'(q[0].k));
            if (rdy) void'(q.pop_front());
        end
        if (v && exp_rdy) begin
            if (k >= NK) begin
                m_idx = 1'b1;
            end else begin
                r.k = k;
                for (int j = 0; j < NK; j++) begin
                    s = (f ? 0 : b24[k][j]) + longint'(lane[j]);
                    r.v24[j] = clamp(s, AW, hit);
                    m_sat24 |= hit;
                    s = (f ? 0 : b17[k][j]) + longint'(lane[j]);
                    r.v17[j] = clamp(s, AWS, hit);
                    m_sat17 |= hit;
                end
                for (int j = 0; j < NK; j++) begin
                    b24[k][j] = l ? 0 : r.v24[j];
                    b17[k][j] = l ? 0 : r.v17[j];
                end
                if (l) q.push_back(r);
            end
        end
        @(posedge i_clk);
        #1;
        chk("sat_err",   128'(o_sat_err), 128'(m_sat24));
        chk("sat_err_s", 128'(s_sat_err), 128'(m_sat17));
        chk("idx_err",   128'(o_idx_err), 128'(m_idx));
        chk("idx_err_s", 128'(s_idx_err), 128'(m_idx));
    endtask

    // Assert reset away from the clock edge and check that the outputs clear
    // before any edge arrives. Then release reset and check ready.
    task automatic do_reset();
        i_psum_valid = 1'b0;
        i_rst = 1'b1;
        #2;
        chk("rst_valid",  128'(o_acc_valid),  128'(0));
        chk("rst_col",    128'(o_acc_col),    128'(0));
        chk("rst_kercol", 128'(o_acc_kercol), 128'(0));
        chk("rst_sat",    128'(o_sat_err),    128'(0));
        chk("rst_idx",    128'(o_idx_err),    128'(0));
        chk("rst_valid_s", 128'(s_acc_valid), 128'(0));
        chk("rst_col_s",   128'(s_acc_col),   128'(0));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 128'(o_psum_ready), 128'(1));
        model_clear();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_psum_col = '0;
        i_kercol_idx = '0;
        i_psum_valid = 1'b0;
        i_first_ch = 1'b0;
        i_last_ch = 1'b0;
        i_acc_ready = 1'b1;
        set_all(0);
        model_clear();
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // T1: a single bank over three channels
        set_all(100); cycle(1, 2, 1, 0, 1);
        set_all(200); cycle(1, 2, 0, 0, 1);
        set_all(300); cycle(1, 2, 0, 1, 1);
        chk("T1_valid",  128'(o_acc_valid),  128'(1));
        chk("T1_col",    128'(o_acc_col),    128'({5{24'd600}}));
        chk("T1_kercol", 128'(o_acc_kercol), 128'(2));
        set_all(0); cycle(0, 0, 0, 0, 1);

        // T2: signed values, two banks interleaved
        set_all(-5); cycle(1, 0, 1, 0, 1);
        set_all(7);  cycle(1, 1, 1, 0, 1);
        set_all(-5); cycle(1, 0, 0, 1, 1);
        chk("T2_col0", 128'(o_acc_col), 128'({5{24'hFFFFF6}}));
        set_all(7);  cycle(1, 1, 0, 1, 1);
        chk("T2_col1", 128'(o_acc_col),    128'({5{24'd14}}));
        chk("T2_k1",   128'(o_acc_kercol), 128'(1));
        set_all(0); cycle(0, 0, 0, 0, 1);

        // T3: backpressure holds the result and stalls a pending beat
        set_all(1);    cycle(1, 4, 1, 0, 1);
        set_all(2);    cycle(1, 4, 0, 1, 0);
        set_all(1000); cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("T3_hold",  128'(o_acc_col),    128'({5{24'd3}}));
        chk("T3_stall", 128'(o_psum_ready), 128'(0));
        set_all(50);   cycle(1, 4, 1, 1, 1);
        chk("T3_b2b_valid", 128'(o_acc_valid), 128'(1));
        chk("T3_b2b_col",   128'(o_acc_col),   128'({5{24'd50}}));
        set_all(0);    cycle(0, 0, 0, 0, 1);
        set_all(0);    cycle(1, 1, 0, 1, 1);
        chk("T3_bank1_untouched", 128'(o_acc_col), 128'(0));
        cycle(0, 0, 0, 0, 1);

        // T4: saturation on lane 0 only
        lane[0] = 32767;
        for (int j = 1; j < NK; j++) lane[j] = 1;
        cycle(1, 3, 1, 0, 1);
        cycle(1, 3, 0, 0, 1);
        cycle(1, 3, 0, 1, 1);
        chk("T4_lane0_s", 128'(s_acc_col[16:0]),  128'(17'h0FFFF));
        chk("T4_lane1_s", 128'(s_acc_col[33:17]), 128'(3));
        chk("T4_sat_s",   128'(s_sat_err),        128'(1));
        chk("T4_lane0",   128'(o_acc_col[23:0]),  128'(98301));
        chk("T4_sat",     128'(o_sat_err),        128'(0));
        set_all(0); cycle(0, 0, 0, 0, 1);

        // T5: an out-of-range index is consumed without side effects
        set_all(5); cycle(1, 0, 1, 0, 1);
        set_all(6); cycle(1, 2, 1, 0, 1);
        set_all(9); cycle(1, 6, 0, 1, 1);
        chk("T5_idx",   128'(o_idx_err),   128'(1));
        chk("T5_noout", 128'(o_acc_valid), 128'(0));
        set_all(0);
        for (int b = 0; b < NK; b++) cycle(1, b, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);

        // T6: reset in mid-accumulation discards partial sums and the pending result
        set_all(11); cycle(1, 3, 1, 0, 1);
        set_all(4);  cycle(1, 2, 1, 1, 0);
        do_reset();
        set_all(9);  cycle(1, 3, 1, 1, 1);
        chk("T6_col", 128'(o_acc_col), 128'({5{24'd9}}));
        set_all(0);  cycle(0, 0, 0, 0, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int k;
            k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            for (int j = 0; j < NK; j++) lane[j] = int'($urandom_range(0, 65535)) - 32768;
            cycle($urandom_range(0, 4) != 0, k, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        set_all(0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
